// File: rtl/nd_2to1_arb_pkg.sv
// Shared types and constants for the 2-to-1 merge node.
// Grant policy values double as the PRIO parameter encoding.
package nd_2to1_arb_pkg;

    localparam int NS_ADDRESS_SIZE = 8;
    localparam int NS_DATA_SIZE    = 8;
    localparam int NS_ARB_RR       = 0;
    localparam int NS_ARB_FIXED    = 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    // pend[0] is rcv0, pend[1] is rcv1; returns the winning index.
    function automatic logic pick_gnt(logic [1:0] pend, logic last_grant, logic fixed);
        logic g;
        if (pend == 2'b11) g = fixed ? 1'b0 : ~last_grant;
        else               g = pend[1];
        return g;
    endfunction

endpackage

// File: rtl/nd_2to1_arb_if.sv
// One 2-phase toggle channel: a message is pending while req != ack.
// Data is held stable by the sender for as long as the message is pending.
interface nd_2to1_arb_if
    import nd_2to1_arb_pkg::*;
#(
    parameter int DSZ = NS_DATA_SIZE
);
    logic           req;
    logic           ack;
    logic [DSZ-1:0] dat;

    modport master (output req, output dat, input ack);
    modport slave  (input req, input dat, output ack);
endinterface

// File: rtl/nd_2to1_arb_arb_rr2.sv
// Two-way grant picker holding the last-grant history; combinational grant, history updates on take.
// No backpressure of its own: the caller decides when a grant is consumed.
module arb_rr2
    import nd_2to1_arb_pkg::*;
#(
    parameter int PRIO = NS_ARB_RR
) (
    input  logic       i_clk,
    input  logic       reset,
    input  logic [1:0] pend,
    input  logic       take,
    output logic       gnt,
    output logic       gnt_vld
);

    logic last_grant;

    always_ff @(posedge i_clk) begin
        if (reset)     last_grant <= 1'b1;
        else if (take) last_grant <= gnt;
    end

    always_comb begin
        gnt_vld = |pend;
        gnt     = pick_gnt(pend, last_grant, PRIO == NS_ARB_FIXED);
    end

endmodule

// File: rtl/nd_2to1_arb.sv
// Merges two toggle channels onto one through a single-message buffer; 1 cycle from pending to snd0_req.
// While the buffered message is unacknowledged no input is acked, so senders simply stay pending.
module nd_2to1_arb
    import nd_2to1_arb_pkg::*;
#(
    parameter int ASZ  = NS_ADDRESS_SIZE,
    parameter int DSZ  = NS_DATA_SIZE,
    parameter int PRIO = NS_ARB_RR,
    parameter int CSZ  = 8
) (
    input  logic           i_clk,
    input  logic           reset,
    output logic           ready,
    nd_2to1_arb_if.slave   rcv0,
    nd_2to1_arb_if.slave   rcv1,
    nd_2to1_arb_if.master  snd0,
    output logic [CSZ-1:0] o_cnt0,
    output logic [CSZ-1:0] o_cnt1
);

    if (ASZ < 1 || DSZ < 1 || CSZ < 1) begin : g_bad_param
        $error("nd_2to1_arb: ASZ, DSZ and CSZ must be positive");
    end

    arb_state_t     state, state_nxt;
    logic [1:0]     pend;
    logic           gnt, gnt_vld, take;
    logic [DSZ-1:0] win_dat;

    assign pend = {rcv1.req ^ rcv1.ack, rcv0.req ^ rcv0.ack};

    arb_rr2 #(.PRIO(PRIO)) u_arb (
        .i_clk   (i_clk),
        .reset   (reset),
        .pend    (pend),
        .take    (take),
        .gnt     (gnt),
        .gnt_vld (gnt_vld)
    );

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        win_dat   = gnt ? rcv1.dat : rcv0.dat;
        case (state)
            ST_IDLE: begin
                if (gnt_vld) begin
                    take      = 1'b1;
                    state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (snd0.ack == snd0.req) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            ready    <= 1'b0;
            rcv0.ack <= 1'b0;
            rcv1.ack <= 1'b0;
            snd0.req <= 1'b0;
            snd0.dat <= '0;
            o_cnt0   <= '0;
            o_cnt1   <= '0;
        end else begin
            ready <= 1'b1;
            state <= state_nxt;
            if (take) begin
                snd0.dat <= win_dat;
                snd0.req <= ~snd0.req;
                // Debug counters stick at all-ones rather than wrapping.
                if (gnt) begin
                    rcv1.ack <= rcv1.req;
                    if (o_cnt1 != '1) o_cnt1 <= o_cnt1 + 1'b1;
                end else begin
                    rcv0.ack <= rcv0.req;
                    if (o_cnt0 != '1) o_cnt0 <= o_cnt0 + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_nd_2to1_arb.sv
// Three merge nodes (round-robin, fixed priority, 4-bit counters) share stimulus timing; a message-level
// model per node is compared against every output on every falling edge.
module tb_nd_2to1_arb;
    import nd_2to1_arb_pkg::*;

    localparam int N = 3;
    localparam int PRIO_OF [N] = '{0, 1, 0};
    localparam int CMAX_OF [N] = '{255, 255, 15};

    logic i_clk = 1'b0;
    logic reset = 1'b1;
    always #5 i_clk = ~i_clk;

    logic       r0_req [N], r1_req [N], s_ack [N];
    logic [7:0] r0_dat [N], r1_dat [N];
    logic       rdy [N], a0 [N], a1 [N], s_req [N];
    logic [7:0] s_dat [N], c0 [N], c1 [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int PR = (g == 1) ? NS_ARB_FIXED : NS_ARB_RR;
        localparam int CW = (g == 2) ? 4 : 8;
        nd_2to1_arb_if #(.DSZ(8)) rcv0_if ();
        nd_2to1_arb_if #(.DSZ(8)) rcv1_if ();
        nd_2to1_arb_if #(.DSZ(8)) snd0_if ();
        logic [CW-1:0] cnt0_w, cnt1_w;
        logic          rdy_w;

        assign rcv0_if.req = r0_req[g];
        assign rcv0_if.dat = r0_dat[g];
        assign rcv1_if.req = r1_req[g];
        assign rcv1_if.dat = r1_dat[g];
        assign snd0_if.ack = s_ack[g];
        assign a0[g]    = rcv0_if.ack;
        assign a1[g]    = rcv1_if.ack;
        assign s_req[g] = snd0_if.req;
        assign s_dat[g] = snd0_if.dat;
        assign c0[g]    = 8'(cnt0_w);
        assign c1[g]    = 8'(cnt1_w);
        assign rdy[g]   = rdy_w;

        nd_2to1_arb #(.ASZ(NS_ADDRESS_SIZE), .DSZ(8), .PRIO(PR), .CSZ(CW)) u_dut (
            .i_clk  (i_clk),
            .reset  (reset),
            .ready  (rdy_w),
            .rcv0   (rcv0_if),
            .rcv1   (rcv1_if),
            .snd0   (snd0_if),
            .o_cnt0 (cnt0_w),
            .o_cnt1 (cnt1_w)
        );
    end

    int n_checks = 0;
    int n_errors = 0;

    function automatic void chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h at %0t", nm, k, act, exp, $time);
        end
    endfunction

    // Sink: acknowledges each outbound message after sink_dly cycles.
    int sink_dly = 0;
    int wait_cnt [N];
    always @(posedge i_clk) begin
        #1;
        for (int k = 0; k < N; k++) begin
            if (reset) begin
                s_ack[k]    = 1'b0;
                wait_cnt[k] = 0;
            end else if (s_req[k] != s_ack[k]) begin
                if (wait_cnt[k] >= sink_dly) begin
                    s_ack[k]    = s_req[k];
                    wait_cnt[k] = 0;
                end else begin
                    wait_cnt[k]++;
                end
            end
        end
    end

    // Reference: the node is either free or holding one message until the sink has consumed it.
    logic       started = 1'b0;
    logic       m_rdy [N], m_free [N], m_prev [N], m_sreq [N], m_a0 [N], m_a1 [N];
    logic [7:0] m_sdat [N];
    int         m_n0 [N], m_n1 [N];

    always @(posedge i_clk) begin
        started = 1'b1;
        for (int k = 0; k < N; k++) begin
            if (reset) begin
                m_rdy[k] = 1'b0; m_free[k] = 1'b1; m_prev[k] = 1'b1; m_sreq[k] = 1'b0;
                m_sdat[k] = 8'd0; m_a0[k] = 1'b0; m_a1[k] = 1'b0; m_n0[k] = 0; m_n1[k] = 0;
            end else begin
                m_rdy[k] = 1'b1;
                if (m_free[k]) begin
                    logic w0, w1, take1;
                    w0 = (r0_req[k] != m_a0[k]);
                    w1 = (r1_req[k] != m_a1[k]);
                    if (w0 || w1) begin
                        take1 = w1 && (!w0 || (PRIO_OF[k] == 0 && m_prev[k] == 1'b0));
                        if (take1) begin
                            m_sdat[k] = r1_dat[k];
                            m_a1[k]   = r1_req[k];
                            if (m_n1[k] < CMAX_OF[k]) m_n1[k]++;
                        end else begin
                            m_sdat[k] = r0_dat[k];
                            m_a0[k]   = r0_req[k];
                            if (m_n0[k] < CMAX_OF[k]) m_n0[k]++;
                        end
                        m_sreq[k] = ~m_sreq[k];
                        m_prev[k] = take1;
                        m_free[k] = 1'b0;
                    end
                end else if (s_ack[k] == m_sreq[k]) begin
                    m_free[k] = 1'b1;
                end
            end
        end
    end

    always @(negedge i_clk) begin
        if (started) begin
            for (int k = 0; k < N; k++) begin
                chk("ready", k, 32'(rdy[k]),   32'(m_rdy[k]));
                chk("snd_req", k, 32'(s_req[k]), 32'(m_sreq[k]));
                chk("snd_dat", k, 32'(s_dat[k]), 32'(m_sdat[k]));
                chk("rcv0_ack", k, 32'(a0[k]), 32'(m_a0[k]));
                chk("rcv1_ack", k, 32'(a1[k]), 32'(m_a1[k]));
                chk("cnt0", k, 32'(c0[k]), 32'(m_n0[k]));
                chk("cnt1", k, 32'(c1[k]), 32'(m_n1[k]));
            end
        end
    end

    // Output order of node 0, captured from its pins.
    logic [7:0] outq0 [$];
    logic       prev_req0 = 1'b0;
    always @(negedge i_clk) begin
        if (!reset && s_req[0] !== prev_req0) outq0.push_back(s_dat[0]);
        prev_req0 = s_req[0];
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push(input int k, input int ch, input logic [7:0] d);
        if (ch == 0) begin r0_dat[k] = d; r0_req[k] = ~r0_req[k]; end
        else         begin r1_dat[k] = d; r1_req[k] = ~r1_req[k]; end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int k = 0; k < N; k++) begin
            r0_req[k] = 1'b0; r1_req[k] = 1'b0; r0_dat[k] = 8'd0; r1_dat[k] = 8'd0;
        end
        repeat (n) tick();
        reset = 1'b0;
        outq0.delete();
    endtask

    int sent0 [N], sent1 [N];
    int ta, tf;

    initial begin
        for (int k = 0; k < N; k++) begin
            r0_req[k] = 1'b0; r1_req[k] = 1'b0; r0_dat[k] = 8'd0; r1_dat[k] = 8'd0;
        end
        do_reset(3);
        chk("rst_ready", 0, 32'(rdy[0]), 0);
        chk("rst_req", 0, 32'(s_req[0]), 0);
        chk("rst_cnt0", 0, 32'(c0[0]), 0);

        // T1: single message, one cycle latency
        tick();
        for (int k = 0; k < N; k++) push(k, 0, 8'd7);
        tick();
        chk("t1_req", 0, 32'(s_req[0]), 1);
        chk("t1_dat", 0, 32'(s_dat[0]), 7);
        chk("t1_ack0", 0, 32'(a0[0]), 1);
        chk("t1_cnt0", 0, 32'(c0[0]), 1);

        // T2: both pending right after reset, rcv0 first
        do_reset(2);
        tick();
        for (int k = 0; k < N; k++) begin push(k, 0, 8'd30); push(k, 1, 8'd12); end
        repeat (6) tick();
        chk("t2_n", 0, 32'(outq0.size()), 2);
        if (outq0.size() == 2) begin
            chk("t2_first", 0, 32'(outq0[0]), 30);
            chk("t2_second", 0, 32'(outq0[1]), 12);
        end
        chk("t2_cnt0", 0, 32'(c0[0]), 1);
        chk("t2_cnt1", 0, 32'(c1[0]), 1);

        // T3: slow sink holds everything, queued rcv1 follows the ack
        sink_dly = 20;
        for (int k = 0; k < N; k++) push(k, 0, 8'h55);
        tick();
        for (int k = 0; k < N; k++) push(k, 1, 8'h66);
        repeat (10) tick();
        chk("t3_hold_dat", 0, 32'(s_dat[0]), 32'h55);
        chk("t3_rcv1_pend", 0, 32'(a1[0] ^ r1_req[0]), 1);
        chk("t3_cnt1", 0, 32'(c1[0]), 1);
        ta = -1; tf = -1;
        for (int t = 0; t < 100; t++) begin
            @(negedge i_clk);
            if (ta < 0 && s_ack[0] == s_req[0]) ta = t;
            if (ta >= 0 && s_dat[0] == 8'h66) begin tf = t; break; end
        end
        chk("t3_fwd_gap", 0, 32'(tf - ta), 2);
        sink_dly = 0;
        repeat (30) tick();

        // T4: continuous streams; fixed priority starves rcv1 until rcv0 stops
        do_reset(2);
        tick();
        for (int k = 0; k < N; k++) begin
            push(k, 0, 8'($urandom)); push(k, 1, 8'hA5); sent0[k] = 1;
        end
        for (int t = 0; t < 80 && c0[1] != 8'd10; t++) begin
            tick();
            for (int k = 0; k < N; k++)
                if (sent0[k] < 10 && r0_req[k] == a0[k]) begin
                    push(k, 0, 8'($urandom)); sent0[k]++;
                end
        end
        chk("t4_cnt0", 1, 32'(c0[1]), 10);
        chk("t4_starved", 1, 32'(c1[1]), 0);
        repeat (6) tick();
        chk("t4_drain", 1, 32'(c1[1]), 1);

        // T5: reset while a message is buffered
        do_reset(2);
        tick();
        sink_dly = 30;
        for (int k = 0; k < N; k++) push(k, 0, 8'd44);
        repeat (2) tick();
        chk("t5_buf_dat", 0, 32'(s_dat[0]), 44);
        chk("t5_buf_req", 0, 32'(s_req[0]), 1);
        reset = 1'b1;
        for (int k = 0; k < N; k++) begin r0_req[k] = 1'b0; r1_req[k] = 1'b0; end
        tick();
        chk("t5_ready", 0, 32'(rdy[0]), 0);
        chk("t5_req", 0, 32'(s_req[0]), 0);
        chk("t5_dat", 0, 32'(s_dat[0]), 0);
        chk("t5_cnt0", 0, 32'(c0[0]), 0);
        reset = 1'b0;
        sink_dly = 0;
        outq0.delete();
        chk("t5_ready_low", 0, 32'(rdy[0]), 0);
        tick();
        chk("t5_ready_up", 0, 32'(rdy[0]), 1);

        // T6: counter saturation on the 4-bit node
        do_reset(2);
        tick();
        for (int k = 0; k < N; k++) sent1[k] = 0;
        for (int t = 0; t < 200; t++) begin
            tick();
            for (int k = 0; k < N; k++)
                if (sent1[k] < 20 && r1_req[k] == a1[k]) begin
                    push(k, 1, 8'(100 + sent1[k])); sent1[k]++;
                end
        end
        chk("t6_sat", 2, 32'(c1[2]), 15);
        chk("t6_cnt_wide", 0, 32'(c1[0]), 20);
        chk("t6_fwd", 0, 32'(outq0.size()), 20);

        // Random traffic with varying sink latency
        do_reset(2);
        for (int t = 0; t < 3000; t++) begin
            if (t % 97 == 0) sink_dly = $urandom_range(0, 3);
            tick();
            for (int k = 0; k < N; k++) begin
                if (r0_req[k] == a0[k] && $urandom_range(0, 99) < 60) push(k, 0, 8'($urandom));
                if (r1_req[k] == a1[k] && $urandom_range(0, 99) < 45) push(k, 1, 8'($urandom));
            end
        end
        sink_dly = 0;
        repeat (10) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
